// File: rtl/rr_grant_ctrl8.sv
// rr_grant_ctrl8: 8-way round-robin arbiter with grant hold timeout.
// Ports: clk, rst (sync, active-high), req[7:0] in; gnt[7:0], gnt_idx[2:0], gnt_valid, preempt out.
module rr_grant_ctrl8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [7:0] MH = 8'(MAX_HOLD);

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic       pre_q, pre_d;

  logic [3:0] a_req, a_rel, a_to;
  logic [2:0] nxt;

  // Returns {found, index}; search starts at p and wraps mod 8.
  // Walks the order backwards so the earliest hit is written last.
  function automatic logic [3:0] arb(input logic [7:0] r,
                                     input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] j;
    res = '0;
    for (int k = 7; k >= 0; k--) begin
      j = p + 3'(k);
      if (r[j]) res = {1'b1, j};
    end
    return res;
  endfunction

  assign nxt   = idx_q + 3'd1;
  assign a_req = arb(req, ptr_q);
  assign a_rel = arb(req, nxt);
  // Timeout search excludes the current holder.
  assign a_to  = arb(req & ~(8'h01 << idx_q), nxt);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    hcnt_d  = hcnt_q;
    pre_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_req[3]) begin
          state_d = GRANT;
          idx_d   = a_req[2:0];
          hcnt_d  = 8'd1;
        end
      end
      GRANT: begin
        if (!req[idx_q]) begin
          ptr_d = nxt;
          if (a_rel[3]) begin
            idx_d  = a_rel[2:0];
            hcnt_d = 8'd1;
          end else begin
            state_d = IDLE;
            hcnt_d  = 8'd0;
          end
        end else if (MAX_HOLD != 0 && hcnt_q == MH) begin
          ptr_d  = nxt;
          hcnt_d = 8'd1;
          // Lone requester is simply re-granted without a pulse.
          if (a_to[3]) begin
            idx_d = a_to[2:0];
            pre_d = 1'b1;
          end
        end else if (hcnt_q != 8'hFF) begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      hcnt_q  <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      hcnt_q  <= hcnt_d;
      pre_q   <= pre_d;
    end
  end

  assign gnt_valid = (state_q == GRANT);
  assign gnt_idx   = idx_q;
  assign preempt   = pre_q;

  // 3-to-8 decoder with enable.
  always_comb begin
    gnt = '0;
    if (gnt_valid) gnt[idx_q] = 1'b1;
  end

endmodule
